// File: rtl/cu_pkg.sv
// Shared control-unit constants: state codes, instruction field positions and type codes.
// Imported by the sequencer and the output encoder so both agree on the state encoding.
package cu_pkg;

  localparam int STATE_W = 7;

  localparam logic [STATE_W-1:0] ST_RESET    = 7'd0;
  localparam logic [STATE_W-1:0] ST_FETCH    = 7'd1;
  localparam logic [STATE_W-1:0] ST_IR_LOAD  = 7'd2;
  localparam logic [STATE_W-1:0] ST_IR_WAIT  = 7'd3;
  localparam logic [STATE_W-1:0] ST_DECODE   = 7'd4;
  localparam logic [STATE_W-1:0] ST_EXEC5    = 7'd5;
  localparam logic [STATE_W-1:0] ST_DP_IMM   = 7'd6;
  localparam logic [STATE_W-1:0] ST_DP_REG   = 7'd7;
  localparam logic [STATE_W-1:0] ST_EXEC8    = 7'd8;
  localparam logic [STATE_W-1:0] ST_BL       = 7'd9;
  localparam logic [STATE_W-1:0] ST_B        = 7'd10;
  localparam logic [STATE_W-1:0] ST_LDST_IMM = 7'd33;
  localparam logic [STATE_W-1:0] ST_LD_WAIT  = 7'd34;
  localparam logic [STATE_W-1:0] ST_LD_DONE  = 7'd35;
  localparam logic [STATE_W-1:0] ST_LD_END   = 7'd36;
  localparam logic [STATE_W-1:0] ST_WB       = 7'd38;
  localparam logic [STATE_W-1:0] ST_ST_ADDR  = 7'd40;
  localparam logic [STATE_W-1:0] ST_ST_DATA  = 7'd41;
  localparam logic [STATE_W-1:0] ST_ST_WAIT  = 7'd42;
  localparam logic [STATE_W-1:0] ST_ST_DONE  = 7'd43;
  localparam logic [STATE_W-1:0] ST_LDST_REG = 7'd46;

  localparam int COND_HI  = 31;
  localparam int TYPE_HI  = 27;
  localparam int LINK_BIT = 24;
  localparam int W_BIT    = 21;
  localparam int L_BIT    = 20;

  localparam logic [2:0] TY_DP_REG   = 3'b000;
  localparam logic [2:0] TY_DP_IMM   = 3'b001;
  localparam logic [2:0] TY_LDST_IMM = 3'b010;
  localparam logic [2:0] TY_LDST_REG = 3'b011;
  localparam logic [2:0] TY_BRANCH   = 3'b101;

  function automatic logic is_wait(input logic [STATE_W-1:0] s);
    return (s == ST_IR_WAIT) || (s == ST_LD_WAIT) || (s == ST_ST_WAIT);
  endfunction

endpackage

// File: rtl/moc_watchdog.sv
// Memory-wait watchdog: counts cycles held in a wait state and raises a sticky error on timeout.
// Instantiated by control_sequencer only when SEQ_MOC_TIMEOUT_EN is defined.
module moc_watchdog #(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic in_wait,
  input  logic moc,
  output logic timeout,
  output logic err
);

  logic [7:0] cnt;

  // cnt is the number of cycles already spent in the current wait state
  assign timeout = in_wait && !moc && (cnt == 8'(MOC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (!in_wait || moc || timeout) cnt <= '0;
      else                            cnt <= cnt + 8'd1;
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Next-state engine of the microprogrammed control unit, with a one-cycle state-change strobe.
// Define SEQ_MOC_TIMEOUT_EN to add the memory-wait watchdog and trap undefined instruction types.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int MOC_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [31:0]        ir,
  input  logic               cond,
  input  logic               moc,
  output logic [STATE_W-1:0] state,
  output logic               state_chg,
  output logic               moc_err
);

  logic [STATE_W-1:0] nxt;
  logic               timeout;

`ifdef SEQ_MOC_TIMEOUT_EN
  localparam logic [STATE_W-1:0] UNDEF_NXT = ST_RESET;

  moc_watchdog #(.MOC_TIMEOUT(MOC_TIMEOUT)) u_wdog (
    .clk     (CLK),
    .clr     (CLR),
    .in_wait (is_wait(state)),
    .moc     (moc),
    .timeout (timeout),
    .err     (moc_err)
  );

  logic unused_ir;
  assign unused_ir = ^{ir[COND_HI -: 4], ir[23:22], ir[19:0]};
`else
  localparam logic [STATE_W-1:0] UNDEF_NXT = ST_FETCH;

  assign timeout = 1'b0;
  assign moc_err = 1'b0;

  logic unused_ir;
  assign unused_ir = ^{ir[COND_HI -: 4], ir[23:22], ir[19:0], 32'(MOC_TIMEOUT)};
`endif

  always_comb begin
    nxt = ST_RESET;
    case (state)
      ST_RESET:   nxt = ST_FETCH;
      ST_FETCH:   nxt = ST_IR_LOAD;
      ST_IR_LOAD: nxt = ST_IR_WAIT;
      ST_IR_WAIT: nxt = moc ? ST_DECODE : ST_IR_WAIT;
      ST_DECODE: begin
        if (!cond) nxt = ST_FETCH;
        else begin
          case (ir[TYPE_HI -: 3])
            TY_DP_REG:   nxt = ST_DP_REG;
            TY_DP_IMM:   nxt = ST_DP_IMM;
            TY_LDST_IMM: nxt = ST_LDST_IMM;
            TY_LDST_REG: nxt = ST_LDST_REG;
            TY_BRANCH:   nxt = ir[LINK_BIT] ? ST_BL : ST_B;
            default:     nxt = UNDEF_NXT;
          endcase
        end
      end
      ST_EXEC5, ST_DP_IMM, ST_DP_REG, ST_EXEC8, ST_BL, ST_B: nxt = ST_FETCH;
      ST_LDST_IMM, ST_LDST_REG: nxt = ir[L_BIT] ? ST_LD_WAIT : ST_ST_ADDR;
      ST_LD_WAIT: nxt = moc ? ST_LD_DONE : ST_LD_WAIT;
      ST_LD_DONE: nxt = ST_LD_END;
      ST_LD_END:  nxt = ir[W_BIT] ? ST_WB : ST_FETCH;
      ST_ST_ADDR: nxt = ST_ST_DATA;
      ST_ST_DATA: nxt = ST_ST_WAIT;
      ST_ST_WAIT: nxt = moc ? ST_ST_DONE : ST_ST_WAIT;
      ST_ST_DONE: nxt = ir[W_BIT] ? ST_WB : ST_FETCH;
      ST_WB:      nxt = ST_FETCH;
      default:    nxt = ST_RESET;
    endcase
    // watchdog expiry overrides the hold in a wait state
    if (timeout) nxt = ST_RESET;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= '0;
      state_chg <= 1'b0;
    end else begin
      state     <= nxt;
      state_chg <= (nxt != state);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: per-cycle vectors with a scoreboard of expected outputs.
module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] ir;
  logic        cond;
  logic        moc;
  logic [6:0]  state;
  logic        state_chg;
  logic        moc_err;

  control_sequencer #(.STATE_W(7), .MOC_TIMEOUT(16)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .ir        (ir),
    .cond      (cond),
    .moc       (moc),
    .state     (state),
    .state_chg (state_chg),
    .moc_err   (moc_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        cond;
    logic        moc;
    logic [6:0]  st;
    logic        chg;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] cur_ir;
  logic        cur_cond;
  logic [6:0]  last_st;
  logic        exp_err;

  task automatic add(input logic clr, input logic m, input int st);
    vec_t v;
    if (clr) exp_err = 1'b0;
    v.clr  = clr;
    v.ir   = cur_ir;
    v.cond = cur_cond;
    v.moc  = m;
    v.st   = 7'(st);
    v.chg  = clr ? 1'b0 : (7'(st) != last_st);
    v.err  = exp_err;
    last_st = 7'(st);
    tbl.push_back(v);
  endtask

  // from state 1 through the fetch sequence to decode, moc high
  task automatic fetch();
    add(1'b0, 1'b1, 2);
    add(1'b0, 1'b1, 3);
    add(1'b0, 1'b1, 4);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int n;

    CLR = 1'b1; ir = '0; cond = 1'b1; moc = 1'b1;
    cur_ir = '0; cur_cond = 1'b1; last_st = '0; exp_err = 1'b0;

    add(1'b1, 1'b1, 0);
    add(1'b1, 1'b1, 0);
    add(1'b0, 1'b1, 1);
    fetch();
    // data processing immediate, executed then skipped
    cur_ir = 32'hE2811001; add(1'b0, 1'b1, 6); add(1'b0, 1'b1, 1); fetch();
    cur_cond = 1'b0; add(1'b0, 1'b1, 1); cur_cond = 1'b1; fetch();
    // LDR with write-back, five cycles in load wait
    cur_ir = 32'hE5B21004;
    add(1'b0, 1'b0, 33); add(1'b0, 1'b0, 34);
    repeat (4) add(1'b0, 1'b0, 34);
    add(1'b0, 1'b1, 35); add(1'b0, 1'b0, 36); add(1'b0, 1'b0, 38); add(1'b0, 1'b0, 1);
    fetch();
    // STR register offset without write-back, moc ignored before the wait state
    cur_ir = 32'hE7821003;
    add(1'b0, 1'b0, 46); add(1'b0, 1'b0, 40); add(1'b0, 1'b0, 41);
    add(1'b0, 1'b0, 42); add(1'b0, 1'b0, 42); add(1'b0, 1'b0, 42);
    add(1'b0, 1'b1, 43); add(1'b0, 1'b0, 1);
    fetch();
    // STR with write-back, moc already high on entry to 42
    cur_ir = 32'hE7A21003;
    add(1'b0, 1'b1, 46); add(1'b0, 1'b1, 40); add(1'b0, 1'b1, 41); add(1'b0, 1'b1, 42);
    add(1'b0, 1'b1, 43); add(1'b0, 1'b1, 38); add(1'b0, 1'b1, 1);
    fetch();
    cur_ir = 32'hEB000010; add(1'b0, 1'b1, 9);  add(1'b0, 1'b1, 1); fetch();
    cur_ir = 32'hEA000010; add(1'b0, 1'b1, 10); add(1'b0, 1'b1, 1); fetch();
    cur_ir = 32'hE0811002; add(1'b0, 1'b1, 7);  add(1'b0, 1'b1, 1); fetch();
    cur_ir = 32'hE8000000;
`ifdef SEQ_MOC_TIMEOUT_EN
    add(1'b0, 1'b1, 0); add(1'b0, 1'b1, 1);
`else
    add(1'b0, 1'b1, 1);
`endif
    fetch();
    // reset while holding in the store wait
    cur_ir = 32'hE7821003;
    add(1'b0, 1'b0, 46); add(1'b0, 1'b0, 40); add(1'b0, 1'b0, 41);
    add(1'b0, 1'b0, 42); add(1'b0, 1'b0, 42);
    add(1'b1, 1'b0, 0);
    add(1'b0, 1'b1, 1);
    fetch();
`ifdef SEQ_MOC_TIMEOUT_EN
    cur_cond = 1'b0; add(1'b0, 1'b1, 1); cur_cond = 1'b1;
    add(1'b0, 1'b0, 2); add(1'b0, 1'b0, 3);
    repeat (15) add(1'b0, 1'b0, 3);
    exp_err = 1'b1;
    add(1'b0, 1'b0, 0);
    add(1'b0, 1'b1, 1);
    fetch();
    add(1'b1, 1'b1, 0);
    add(1'b0, 1'b1, 1);
`endif

    foreach (tbl[i]) begin
      CLR  = tbl[i].clr;
      ir   = tbl[i].ir;
      cond = tbl[i].cond;
      moc  = tbl[i].moc;
      sb.push_back(tbl[i]);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk("state", i, int'(state), int'(e.st));
      chk("state_chg", i, int'(state_chg), int'(e.chg));
      chk("moc_err", i, int'(moc_err), int'(e.err));
    end

    // bounded wait for decode after a reset pulse
    CLR = 1'b1; moc = 1'b1;
    @(posedge CLK); #1;
    chk("pulse_reset_state", 0, int'(state), 0);
    CLR = 1'b0;
    n = 0;
    while (state != 7'd4 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("release_to_decode_cycles", 0, n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
